// File: rtl/image_window_ctrl_pkg.sv
// image_window_ctrl_pkg: shared state encoding and default geometry for the
// window sequencer and the window RAM that sits beside it.
package image_window_ctrl_pkg;
  localparam int DEF_NUM_WORDS = 9;
  localparam int DEF_ADDR_W    = 4;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_PASS_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/image_window_ctrl.sv
// image_window_ctrl: loads one 3x3 window into the window RAM, then replays it
// npass times to the MAC with first/last markers.
module image_window_ctrl
  import image_window_ctrl_pkg::*;
#(
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int PASS_W    = DEF_PASS_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PASS_W-1:0] num_passes,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_first,
  output logic              out_last
);
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  logic [PASS_W-1:0]   npass_q, npass_d;
  logic                last_w;

  assign last_w = cnt_q == ADDR_W'(NUM_WORDS - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pass_q  <= '0;
      npass_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      npass_q <= npass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    npass_d = npass_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        cnt_d   = '0;
        pass_d  = '0;
        npass_d = (num_passes == '0) ? PASS_W'(1) : num_passes;
      end
      LOAD: if (in_valid) begin
        state_d = last_w ? READ : LOAD;
        cnt_d   = last_w ? '0 : cnt_q + 1'b1;
        pass_d  = '0;
      end
      READ: if (out_ready) begin
        cnt_d = last_w ? '0 : cnt_q + 1'b1;
        if (last_w) begin
          state_d = (pass_q == npass_q - 1'b1) ? DONE : READ;
          pass_d  = (pass_q == npass_q - 1'b1) ? pass_q : pass_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Everything is gated by state so all outputs read 0 outside their phase.
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign in_ready  = state_q == LOAD;
  assign ram_wen   = in_valid & in_ready;
  assign ram_waddr = in_ready ? cnt_q : '0;
  assign ram_wdata = in_ready ? in_data : '0;
  assign out_valid = state_q == READ;
  assign ram_raddr = out_valid ? cnt_q : '0;
  assign out_data  = out_valid ? ram_rdata : '0;
  assign out_first = out_valid & (cnt_q == '0);
  assign out_last  = out_valid & last_w;
endmodule
